// File: rtl/mem_bus_responder.sv
// CPU memory-bus responder: ROM (preloadable), RAM, one output register and open-bus space.
// Latency: ready is registered WAIT_STATES edges after the accepting edge; requests are only taken in IDLE.
module mem_bus_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned RAM_AW      = 10,
  parameter logic [15:0] IO_ADDR     = 16'hFF00,
  parameter logic [7:0]  OPEN_BUS    = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_bus,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_oe,
  output logic        ready,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [7:0]  load_data,
  output logic [7:0]  io_data,
  output logic        io_strobe,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]        WS_INIT  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [16:0]       RAM_END  = 17'h100 + (17'd1 << RAM_AW);
  localparam logic [RAM_AW-1:0] RAM_BASE = RAM_AW'(256);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        rd_q, wr_q;

  logic [7:0]  rom [256];
  logic [7:0]  ram [2**RAM_AW];

  logic        accept, enter_done;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;
  logic        cur_rd, cur_wr, cur_write_only;
  logic        is_rom, is_ram, is_io, acc_err;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]  rd_dat;
  logic        ram_we, io_we;

  // A pending preload owns the IDLE edge; the bus request waits for the next one.
  assign accept = (state_q == S_IDLE) && !load_en && (mem_read || mem_write);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_done = (state_q != S_DONE) && (state_d == S_DONE);

  // With zero wait states the access completes on its accepting edge, before the latches load.
  assign cur_addr       = (state_q == S_IDLE) ? addr_bus  : addr_q;
  assign cur_wdata      = (state_q == S_IDLE) ? wdata     : wdata_q;
  assign cur_rd         = (state_q == S_IDLE) ? mem_read  : rd_q;
  assign cur_wr         = (state_q == S_IDLE) ? mem_write : wr_q;
  assign cur_write_only = cur_wr && !cur_rd;

  assign is_rom  = cur_addr < 16'h0100;
  assign is_ram  = !is_rom && ({1'b0, cur_addr} < RAM_END);
  assign is_io   = !is_rom && !is_ram && (cur_addr == IO_ADDR);
  assign ram_idx = cur_addr[RAM_AW-1:0] - RAM_BASE;

  assign acc_err = (cur_rd && cur_wr)
                 || (cur_write_only && is_rom)
                 || (!is_rom && !is_ram && !is_io);

  assign ram_we = enter_done && cur_write_only && is_ram;
  assign io_we  = enter_done && cur_write_only && is_io;

  always_comb begin
    rd_dat = OPEN_BUS;
    if (is_rom)      rd_dat = rom[cur_addr[7:0]];
    else if (is_ram) rd_dat = ram[ram_idx];
    else if (is_io)  rd_dat = io_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rdata     <= 8'h00;
      rdata_oe  <= 1'b0;
      ready     <= 1'b0;
      io_data   <= 8'h00;
      io_strobe <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready     <= enter_done;
      rdata_oe  <= enter_done && cur_rd;
      io_strobe <= io_we;
      if (accept) begin
        addr_q  <= addr_bus;
        wdata_q <= wdata;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
      end
      if (enter_done && cur_rd) rdata   <= rd_dat;
      if (io_we)                io_data <= cur_wdata;
      if (enter_done && acc_err) bus_err <= 1'b1;
    end
  end

  // Arrays keep their contents across reset; a write caught by reset is never committed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((state_q == S_IDLE) && load_en) rom[load_addr] <= load_data;
      if (ram_we)                         ram[ram_idx]   <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (WAIT_STATES 1, 0, 3) against a behavioural memory-map model.
module tb_mem_bus_responder;

  localparam int NU = 3;
  int ws_of [NU] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a   [NU];
  logic        rd  [NU];
  logic        wr  [NU];
  logic [7:0]  wd  [NU];
  logic        le  [NU];
  logic [7:0]  la  [NU];
  logic [7:0]  ld  [NU];
  logic [7:0]  rdat[NU];
  logic        oe  [NU];
  logic        rdy [NU];
  logic [7:0]  iod [NU];
  logic        stb [NU];
  logic        err [NU];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    mem_bus_responder #(
      .WAIT_STATES((g == 1) ? 0 : ((g == 0) ? 1 : 3))
    ) dut (
      .clk(clk), .reset(rst),
      .addr_bus(a[g]), .mem_read(rd[g]), .mem_write(wr[g]), .wdata(wd[g]),
      .rdata(rdat[g]), .rdata_oe(oe[g]), .ready(rdy[g]),
      .load_en(le[g]), .load_addr(la[g]), .load_data(ld[g]),
      .io_data(iod[g]), .io_strobe(stb[g]), .bus_err(err[g])
    );
  end

  // Behavioural model of the memory map.
  logic [7:0] m_rom   [NU][256];
  logic [7:0] m_ram   [NU][1024];
  bit         m_known [NU][1024];
  logic [7:0] m_io    [NU];
  bit         m_err   [NU];

  int vec  = 0;
  int miss = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_access(input int u, input bit r, input bit w, input logic [15:0] addr,
                              input logic [7:0] d, output logic [7:0] exp_rd,
                              output bit exp_known, output bit exp_stb);
    int  ai  = int'(addr);
    bit  bad = (r && w);
    exp_rd = 8'hFF; exp_known = 1'b1; exp_stb = 1'b0;
    if (ai < 256) begin
      exp_rd = m_rom[u][ai];
      if (w && !r) bad = 1'b1;
    end else if (ai < 256 + 1024) begin
      exp_rd    = m_ram[u][ai - 256];
      exp_known = m_known[u][ai - 256];
      if (w && !r) begin
        m_ram[u][ai - 256]   = d;
        m_known[u][ai - 256] = 1'b1;
      end
    end else if (ai == 16'hFF00) begin
      exp_rd = m_io[u];
      if (w && !r) begin
        m_io[u] = d;
        exp_stb = 1'b1;
      end
    end else begin
      bad = 1'b1;
    end
    if (bad) m_err[u] = 1'b1;
  endtask

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      m_io[u]  = 8'h00;
      m_err[u] = 1'b0;
    end
  endtask

  // One complete bus access on unit u, checked against the model; latency counted in edges after acceptance.
  task automatic access(input int u, input bit r, input bit w, input logic [15:0] addr,
                        input logic [7:0] d, input string tag,
                        output logic [7:0] got_rd, output logic got_err);
    logic [7:0] er;
    bit ek, es;
    int lat;
    model_access(u, r, w, addr, d, er, ek, es);
    @(negedge clk);
    a[u] = addr; rd[u] = r; wr[u] = w; wd[u] = d;
    @(posedge clk);
    @(negedge clk);
    rd[u] = 1'b0; wr[u] = 1'b0;
    lat = 0;
    while (!rdy[u] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got_rd  = rdat[u];
    got_err = err[u];
    check({tag, "/latency"}, lat, ws_of[u]);
    check({tag, "/rdata_oe"}, oe[u], r);
    if (r && ek) check({tag, "/rdata"}, rdat[u], er);
    check({tag, "/io_strobe"}, stb[u], es);
    check({tag, "/io_data"}, iod[u], m_io[u]);
    check({tag, "/bus_err"}, err[u], m_err[u]);
    @(negedge clk);
    check({tag, "/ready_1cyc"}, rdy[u], 1'b0);
    check({tag, "/oe_1cyc"}, oe[u], 1'b0);
    check({tag, "/strobe_1cyc"}, stb[u], 1'b0);
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [15:0] addr;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
    bit          exp_err;
  } vec_t;

  initial begin
    vec_t       tbl [13];
    logic [7:0] grd;
    logic       gerr;
    logic [7:0] rv;

    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'hA9, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0001, 8'h00, 8'h55, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h0100, 8'h5A, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'h5A, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'h04FF, 8'h11, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h04FF, 8'h00, 8'h11, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'h0002, 8'h33, 8'h00, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 16'h0002, 8'h00, 8'h3E, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 16'hFF00, 8'h7E, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 16'hFF00, 8'h00, 8'h7E, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 16'h0500, 8'h00, 8'hFF, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 16'h0100, 8'h00, 8'h5A, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'h5A, 1'b1};

    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      a[u] = 16'h0; rd[u] = 1'b0; wr[u] = 1'b0; wd[u] = 8'h0;
      le[u] = 1'b0; la[u] = 8'h0; ld[u] = 8'h0;
      for (int i = 0; i < 1024; i++) m_known[u][i] = 1'b0;
    end
    model_reset();

    @(negedge clk);
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("reset/u%0d/rdata", u), rdat[u], 8'h00);
      check($sformatf("reset/u%0d/rdata_oe", u), oe[u], 1'b0);
      check($sformatf("reset/u%0d/ready", u), rdy[u], 1'b0);
      check($sformatf("reset/u%0d/io_data", u), iod[u], 8'h00);
      check($sformatf("reset/u%0d/io_strobe", u), stb[u], 1'b0);
      check($sformatf("reset/u%0d/bus_err", u), err[u], 1'b0);
    end
    rst = 1'b0;

    // ROM preload on every instance.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      rv = (i == 0) ? 8'hA9 : ((i == 1) ? 8'h55 : (8'(i) ^ 8'h3C));
      for (int u = 0; u < NU; u++) begin
        le[u] = 1'b1; la[u] = 8'(i); ld[u] = rv;
        m_rom[u][i] = rv;
      end
    end
    @(negedge clk);
    for (int u = 0; u < NU; u++) le[u] = 1'b0;

    // Directed table on the one-wait-state instance.
    for (int i = 0; i < 13; i++) begin
      access(0, tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].d, $sformatf("tbl%0d", i), grd, gerr);
      if (tbl[i].r) check($sformatf("tbl%0d/table_rdata", i), grd, tbl[i].exp_rd);
      check($sformatf("tbl%0d/table_err", i), gerr, tbl[i].exp_err);
    end

    // Reset while a RAM write sits in WAIT: nothing commits, outputs clear at once.
    access(0, 1'b0, 1'b1, 16'h0200, 8'h42, "pre_abort", grd, gerr);
    access(0, 1'b1, 1'b0, 16'h0001, 8'h00, "pre_abort_rd", grd, gerr);
    @(negedge clk);
    a[0] = 16'h0200; wr[0] = 1'b1; wd[0] = 8'h99;
    @(posedge clk);
    @(negedge clk);
    wr[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("abort/ready", rdy[0], 1'b0);
    check("abort/rdata", rdat[0], 8'h00);
    check("abort/rdata_oe", oe[0], 1'b0);
    check("abort/io_data", iod[0], 8'h00);
    check("abort/io_strobe", stb[0], 1'b0);
    check("abort/bus_err", err[0], 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort/no_ready%0d", k), rdy[0], 1'b0);
    end
    access(0, 1'b1, 1'b0, 16'h0200, 8'h00, "post_abort", grd, gerr);
    check("post_abort/ram_kept", grd, 8'h42);

    // Zero wait states, read held high, preload colliding with the first IDLE edge.
    @(negedge clk);
    a[1] = 16'h0010; rd[1] = 1'b1;
    le[1] = 1'b1; la[1] = 8'h10; ld[1] = 8'hC3;
    m_rom[1][16] = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    le[1] = 1'b0;
    check("hold/edge1_ready", rdy[1], 1'b0);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("hold/edge%0d_ready", k), rdy[1], (k % 2) == 0);
      if ((k % 2) == 0) check($sformatf("hold/edge%0d_rdata", k), rdat[1], 8'hC3);
    end
    rd[1] = 1'b0;
    @(negedge clk);

    // Randomised accesses on every instance.
    for (int u = 0; u < NU; u++) begin
      for (int n = 0; n < 60; n++) begin
        logic [15:0] ra;
        int          op;
        bit          r, w;
        case ($urandom_range(0, 7))
          0: ra = 16'($urandom_range(0, 255));
          1: ra = 16'(16'h0100 + $urandom_range(0, 1023));
          2: ra = 16'h0100;
          3: ra = 16'h04FF;
          4: ra = 16'h0500;
          5: ra = 16'hFF00;
          6: ra = 16'h00FF;
          default: ra = 16'($urandom);
        endcase
        op = $urandom_range(0, 9);
        r  = (op < 5) || (op == 9);
        w  = (op >= 5);
        access(u, r, w, ra, 8'($urandom), $sformatf("rnd/u%0d/%0d", u, n), grd, gerr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
